seq_divider: RTL



---
 rtl/seq_divider_pkg.sv | 20 ++
 rtl/seq_divider_div_step.sv | 24 ++
 rtl/seq_divider.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the iterative restoring divider.
// Imported by the divider top and its datapath step.
package seq_divider_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  // Counter width for a given dividend width; never narrower than one bit.
  function automatic int cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DW_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit,
// then subtract the divisor if it fits.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] r_in,
  input  logic          bit_in,
  input  logic [VW-1:0] v,
  output logic [VW-1:0] r_out,
  output logic          q_bit
);

  logic [VW:0] r_shift;
  logic [VW:0] diff;

  always_comb begin
    r_shift = {r_in, bit_in};
    diff    = r_shift - {1'b0, v};
    q_bit   = (r_shift >= {1'b0, v});
    // Either branch is below v, so the result always fits in VW bits.
    r_out   = VW'(q_bit ? diff : r_shift);
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Handshake: start is taken only while busy=0; done pulses for one cycle and results hold until the next completion.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output state_e        state_dbg
);

  localparam int CW = cnt_w(DW);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] d_q, d_d;
  logic [VW-1:0] v_q, v_d;
  // The partial remainder after each step is below v, so VW bits are enough to store it.
  logic [VW-1:0] r_q, r_d;
  // The final quotient bit comes straight from the last step, so DW-1 bits are stored.
  logic [DW-2:0] q_q, q_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic [VW-1:0] step_r;
  logic          step_q;

  div_step #(.VW(VW)) u_step (
    .r_in   (r_q),
    .bit_in (d_q[DW-1]),
    .v      (v_q),
    .r_out  (step_r),
    .q_bit  (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    v_d         = v_q;
    r_d         = r_q;
    q_d         = q_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (busy_q) begin
          // Zero divisor accepted on the previous edge: finish it now.
          done_d      = 1'b1;
          busy_d      = 1'b0;
          quotient_d  = '1;
          remainder_d = d_q[VW-1:0];
          dbz_d       = 1'b1;
        end else if (start) begin
          d_d    = dividend;
          v_d    = divisor;
          r_d    = '0;
          q_d    = '0;
          cnt_d  = CW'(DW - 1);
          busy_d = 1'b1;
          if (divisor != '0) state_d = RUN;
        end
      end
      RUN: begin
        d_d   = {d_q[DW-2:0], 1'b0};
        r_d   = step_r;
        q_d   = {q_q[DW-3:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quotient_d  = {q_q, step_q};
          remainder_d = step_r;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      d_q         <= '0;
      v_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      v_q         <= v_d;
      r_q         <= r_d;
      q_q         <= q_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule
